// File: rtl/note_voice_scheduler.sv
// Assigns note events to the lowest free note_player voice, runs a per-voice
// beat counter for the note's duration, and retires it with a one-cycle note_done.
module note_voice #(
  parameter int DUR_WIDTH = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_play,
  input  logic                 i_beat,
  input  logic                 i_sel,
  input  logic [DUR_WIDTH-1:0] i_dur,
  output logic                 o_idle,
  output logic                 o_load,
  output logic                 o_active,
  output logic                 o_done
);
  typedef enum logic [1:0] {IDLE, LOAD, PLAYING, DONE} state_t;

  state_t               r_state;
  logic [DUR_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_sel) begin
          r_state <= LOAD;
          r_cnt   <= i_dur;
        end
        // beats arriving while in LOAD are deliberately not counted
        LOAD: r_state <= (r_cnt != '0) ? PLAYING : DONE;
        PLAYING: if (i_play && i_beat) begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == {{(DUR_WIDTH-1){1'b0}}, 1'b1}) r_state <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_idle   = (r_state == IDLE);
  assign o_load   = (r_state == LOAD);
  assign o_active = (r_state == LOAD) || (r_state == PLAYING);
  assign o_done   = (r_state == DONE);
endmodule

module note_voice_scheduler #(
  parameter int NUM_VOICES = 3,
  parameter int DUR_WIDTH  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_play,
  input  logic                  i_beat,
  input  logic                  i_note_valid,
  input  logic [5:0]            i_note_in,
  input  logic [DUR_WIDTH-1:0]  i_duration_in,
  output logic                  o_note_ready,
  output logic [5:0]            o_note_to_load,
  output logic [NUM_VOICES-1:0] o_load_new_note,
  output logic [NUM_VOICES-1:0] o_play_enable,
  output logic [NUM_VOICES-1:0] o_note_done,
  output logic [NUM_VOICES-1:0] o_voice_busy,
  output logic                  o_all_idle
);
  logic [NUM_VOICES-1:0] w_idle, w_first, w_sel, w_active;
  logic                  w_found, w_accept;
  logic [5:0]            r_note_to_load;

  assign o_note_ready = i_play && !i_reset && ((|w_idle) || (i_note_in == 6'd0));
  assign w_accept     = i_note_valid && o_note_ready && (i_note_in != 6'd0);

  // lowest-index idle voice wins
  always_comb begin
    w_first = '0;
    w_found = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (w_idle[v] && !w_found) begin
        w_first[v] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign w_sel = w_first & {NUM_VOICES{w_accept}};

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    note_voice #(.DUR_WIDTH(DUR_WIDTH)) u_voice (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_play   (i_play),
      .i_beat   (i_beat),
      .i_sel    (w_sel[g]),
      .i_dur    (i_duration_in),
      .o_idle   (w_idle[g]),
      .o_load   (o_load_new_note[g]),
      .o_active (w_active[g]),
      .o_done   (o_note_done[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)       r_note_to_load <= 6'd0;
    else if (w_accept) r_note_to_load <= i_note_in;
  end

  assign o_note_to_load = r_note_to_load;
  assign o_play_enable  = w_active & {NUM_VOICES{i_play}};
  assign o_voice_busy   = ~w_idle;
  assign o_all_idle     = &w_idle;
endmodule

// File: tb/tb_note_voice_scheduler.sv
// Randomized + directed bench; a timeline model predicts load/done events into
// scoreboard queues that a negedge monitor drains against the DUT outputs.
module tb_note_voice_scheduler;
  localparam int NV  = 3;
  localparam int DW  = 6;
  localparam int BIG = 32'h7fffffff;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1, i_play = 1'b0, i_beat = 1'b0, i_note_valid = 1'b0;
  logic [5:0]    i_note_in = '0;
  logic [DW-1:0] i_duration_in = '0;
  logic          o_note_ready, o_all_idle;
  logic [5:0]    o_note_to_load;
  logic [NV-1:0] o_load_new_note, o_play_enable, o_note_done, o_voice_busy;

  note_voice_scheduler #(.NUM_VOICES(NV), .DUR_WIDTH(DW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_play(i_play), .i_beat(i_beat),
    .i_note_valid(i_note_valid), .i_note_in(i_note_in), .i_duration_in(i_duration_in),
    .o_note_ready(o_note_ready), .o_note_to_load(o_note_to_load),
    .o_load_new_note(o_load_new_note), .o_play_enable(o_play_enable),
    .o_note_done(o_note_done), .o_voice_busy(o_voice_busy), .o_all_idle(o_all_idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int e = 0;  // edge count; the cycle following edge e is labelled e

  typedef struct { int cyc; logic [NV-1:0] mask; logic [5:0] note; } ev_t;
  ev_t ldq[$], dnq[$];

  // model: a voice is a note occupying a span of cycles [acc, done]
  bit         m_busy[NV];
  int         m_acc[NV], m_rem[NV], m_done[NV];
  logic [5:0] m_note = '0;
  bit         m_rdy;
  int         m_sel;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, e, act, exp);
    end
  endtask

  function automatic bit m_idle(int v, int c);
    return !m_busy[v] || c > m_done[v];
  endfunction

  function automatic bit m_ready(int c);
    bit any = 0;
    for (int v = 0; v < NV; v++) if (m_idle(v, c)) any = 1;
    return i_play && !i_reset && (any || i_note_in == 6'd0);
  endfunction

  task automatic push_done(int c, int v);
    ev_t t;
    if (dnq.size() > 0 && dnq[$].cyc == c) t = dnq.pop_back();
    else begin t.cyc = c; t.mask = '0; t.note = '0; end
    t.mask[v] = 1'b1;
    dnq.push_back(t);
  endtask

  always @(posedge clk) begin
    e++;
    if (i_reset) begin
      for (int v = 0; v < NV; v++) m_busy[v] = 0;
      m_note = '0;
      while (ldq.size() > 0 && ldq[$].cyc >= e) void'(ldq.pop_back());
      while (dnq.size() > 0 && dnq[$].cyc >= e) void'(dnq.pop_back());
    end else begin
      m_rdy = m_ready(e - 1);
      if (i_play && i_beat)
        for (int v = 0; v < NV; v++)
          if (m_busy[v] && m_done[v] == BIG && e >= m_acc[v] + 2) begin
            m_rem[v]--;
            if (m_rem[v] == 0) begin m_done[v] = e; push_done(e, v); end
          end
      if (i_note_valid && m_rdy && i_note_in != 6'd0) begin
        m_sel = -1;
        for (int v = 0; v < NV; v++) if (m_sel < 0 && m_idle(v, e - 1)) m_sel = v;
        m_busy[m_sel] = 1;
        m_acc[m_sel]  = e;
        m_rem[m_sel]  = int'(i_duration_in);
        m_done[m_sel] = (i_duration_in == '0) ? e + 1 : BIG;
        m_note = i_note_in;
        begin
          ev_t t;
          t.cyc = e; t.mask = '0; t.mask[m_sel] = 1'b1; t.note = i_note_in;
          ldq.push_back(t);
        end
        if (i_duration_in == '0) push_done(e + 1, m_sel);
      end
    end
  end

  // monitor
  logic [NV-1:0] x_busy, x_pe;
  ev_t h;
  always @(negedge clk) if (e >= 1) begin
    x_busy = '0; x_pe = '0;
    for (int v = 0; v < NV; v++) begin
      x_busy[v] = !m_idle(v, e);
      x_pe[v]   = i_play && m_busy[v] && e >= m_acc[v] && e < m_done[v];
    end
    chk("note_ready", o_note_ready, m_ready(e));
    chk("voice_busy", o_voice_busy, x_busy);
    chk("all_idle", o_all_idle, x_busy == '0);
    chk("play_enable", o_play_enable, x_pe);
    chk("note_to_load", o_note_to_load, m_note);
    if (o_load_new_note != '0 || (ldq.size() > 0 && ldq[0].cyc <= e)) begin
      if (ldq.size() == 0) chk("load_unexpected", o_load_new_note, '0);
      else begin
        h = ldq.pop_front();
        chk("load_cycle", e, h.cyc);
        chk("load_mask", o_load_new_note, h.mask);
        chk("load_note", o_note_to_load, h.note);
      end
    end
    if (o_note_done != '0 || (dnq.size() > 0 && dnq[0].cyc <= e)) begin
      if (dnq.size() == 0) chk("done_unexpected", o_note_done, '0);
      else begin
        h = dnq.pop_front();
        chk("done_cycle", e, h.cyc);
        chk("done_mask", o_note_done, h.mask);
      end
    end
  end

  bit beat_auto = 1'b0;
  int beat_div  = 3;

  task automatic tick();
    @(posedge clk); #1;
    if (beat_auto) i_beat = ($urandom_range(0, beat_div - 1) == 0);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_beat();
    i_beat = 1'b1; tick(); i_beat = 1'b0;
  endtask

  task automatic send(logic [5:0] note, int dur);
    bit r = 0;
    int n = 0;
    i_note_valid = 1'b1; i_note_in = note; i_duration_in = DW'(dur);
    while (!r && n < 3000) begin
      @(negedge clk); r = o_note_ready; n++;
      tick();
    end
    if (!r) chk("send_timeout", 1, 0);
    i_note_valid = 1'b0;
  endtask

  initial begin
    ticks(3);
    i_reset = 1'b0; i_play = 1'b1;
    // single note, duration 3
    beat_auto = 1; beat_div = 4;
    send(6'd45, 3); ticks(40);
    // four back-to-back notes, fourth waits for voice 0
    send(6'd45, 4); send(6'd32, 4); send(6'd20, 4); send(6'd10, 4); ticks(40);
    // pause mid-note after one counted beat
    beat_auto = 0; i_beat = 1'b0;
    send(6'd40, 2); ticks(2); pulse_beat(); ticks(2);
    i_play = 1'b0;
    for (int i = 0; i < 50; i++) begin pulse_beat(); ticks(9); end
    i_play = 1'b1; ticks(3); pulse_beat(); ticks(4);
    // rest and zero duration
    send(6'd0, 5); ticks(3);
    send(6'd12, 0); ticks(4);
    // beat coincident with the accepting edge
    i_beat = 1'b1; send(6'd33, 2); i_beat = 1'b0;
    ticks(2); pulse_beat(); ticks(2); pulse_beat(); ticks(4);
    // reset while three voices play
    beat_auto = 1; beat_div = 3;
    send(6'd1, 20); send(6'd2, 20); send(6'd3, 20); ticks(10);
    i_reset = 1'b1; tick(); i_reset = 1'b0; ticks(3);
    // maximum duration
    beat_div = 2;
    send(6'd7, 63); ticks(5);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      i_note_valid  = $urandom_range(0, 1);
      i_note_in     = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      i_duration_in = DW'($urandom_range(0, 5));
      i_play        = ($urandom_range(0, 7) != 0);
      i_reset       = ($urandom_range(0, 99) == 0);
      tick();
    end
    i_note_valid = 1'b0; i_reset = 1'b0; i_play = 1'b1;
    for (int i = 0; i < 3000 && (ldq.size() > 0 || dnq.size() > 0); i++) tick();
    ticks(2);
    chk("drain_empty", ldq.size() + dnq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/note_voice_scheduler.md
# note_voice_scheduler

Schedules incoming note events onto a bank of `note_player` voices. Each accepted note goes to the lowest-indexed free voice. The scheduler loads the voice, counts the note's duration in beats from `beat_generator`, and retires it with a one-cycle `note_done`. It sits between the song reader and the `note_player` bank, and owns every voice's `play_enable`, `load_new_note` and `note_done` inputs.

## Interface
- `NUM_VOICES`, default 3: number of `note_player` instances driven, range 1–8.
- `DUR_WIDTH`, default 6: width of the duration field, counted in beats.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high; clears all state.
- `play` in 1: global run/pause.
- `beat` in 1: one-cycle tick from `beat_generator`.
- `note_valid` in 1: a note event is presented.
- `note_in` in 6: note number; 0 means rest.
- `duration_in` in DUR_WIDTH: length in beats.
- `note_ready` out 1: the scheduler accepts the event this cycle.
- `note_to_load` out 6: shared note bus to all voices.
- `load_new_note` out NUM_VOICES: one-hot load strobe.
- `play_enable` out NUM_VOICES: per-voice enable.
- `note_done` out NUM_VOICES: one-cycle end-of-note pulse.
- `voice_busy` out NUM_VOICES: voice is not IDLE.
- `all_idle` out 1: every voice is IDLE.

## Operation
- Per-voice FSM with states IDLE, LOAD, PLAYING, DONE; each voice has a DUR_WIDTH down-counter `cnt`.
- Transitions:
  - IDLE → LOAD when the voice is selected by an accept.
  - LOAD → PLAYING if the latched duration is nonzero; LOAD → DONE if it is 0.
  - PLAYING → DONE on a `beat && play` cycle with `cnt == 1`. Otherwise `beat && play` decrements `cnt`.
  - DONE → IDLE unconditionally.
- `note_ready = play && !reset && (some voice IDLE || note_in == 0)`. The IDLE test uses registered state only.
- An accept is `note_valid && note_ready` at a clock edge.
  - Rest (`note_in == 0`): consumed, no voice is touched, no outputs change.
  - Otherwise the lowest-index IDLE voice `i` is selected. At the same edge, `cnt[i]` is set to `duration_in` and `note_to_load` is set to `note_in`.
- At most one accept per cycle, so one shared `note_to_load` bus is sufficient. It holds its value until the next non-rest accept.
- `load_new_note[i] = (state[i] == LOAD)`.
- `note_done[i] = (state[i] == DONE)`.
- `play_enable[i] = play && (state[i] == LOAD || state[i] == PLAYING)`.
- `voice_busy[i] = (state[i] != IDLE)`.
- `all_idle = ~|voice_busy`.
- `play` low: counters freeze, no accepts, `play_enable` all 0. FSMs still advance LOAD → PLAYING/DONE and DONE → IDLE.
- No voice stealing: when every voice is busy, `note_ready` stays low until one returns to IDLE.

## Timing
- Reset values: all voices IDLE, `cnt = 0`, `note_to_load = 0`, `load_new_note`/`note_done`/`play_enable`/`voice_busy = 0`, `all_idle = 1`, `note_ready = 0` while reset is high.
- Reset mid-note drops all voices to IDLE on that edge. No `note_done` is emitted for notes killed by reset.
- Cycle-level timeline for an accept at edge k:
  - Cycle k+1: LOAD; `load_new_note[i] = 1`; `note_to_load` is valid.
  - Cycle k+2: PLAYING (or DONE if the duration was 0).
- A `beat` during LOAD is ignored, so counting starts with the first `beat` in PLAYING.
- With duration D ≥ 1, `note_done[i]` is high exactly in the cycle after the D-th counted beat.
- A voice in DONE is not free that cycle. It is selectable from the following cycle, after returning to IDLE.
- Simultaneous accept and `beat` in the same cycle: the newly loaded voice does not count that beat. Other voices count it normally.
- Multiple voices can reach DONE in the same cycle. Their `note_done` bits assert together.
- `duration_in` wrap is impossible. The maximum is 2^DUR_WIDTH−1 beats.

## Test plan
- Reset, then `note_in = 45`, `duration_in = 3`, `play = 1` → voice 0:
  - `load_new_note = 3'b001` one cycle after accept; `note_to_load = 45`.
  - `note_done[0]` pulses one cycle after the 3rd beat.
  - `all_idle` returns to 1.
- Four back-to-back notes (45, 32, 20, 10), duration 4:
  - Voices 0, 1, 2 load on consecutive cycles.
  - `note_ready` stays low for the 4th note until voice 0 completes.
  - The 4th note then goes to voice 0.
- `play` dropped for 500 cycles mid-note (duration 2, one beat counted) → `play_enable = 0`, no `note_done`. On resume, completion comes after exactly one more beat.
- Rest and zero-duration:
  - `note_in = 0` is accepted with no `load_new_note`.
  - `note_in = 12`, `duration = 0` → LOAD then DONE: `note_done` is 2 cycles after accept.
- `beat` coincident with the accept edge → the new voice still needs D further beats, checked with D = 2.
- `reset` asserted while 3 voices are PLAYING → all outputs return to reset values on that edge, with no `note_done` pulse.
